fsmotor_stepgen: RTL

//  Per-motor step/direction pulse generator feeding one sN_* slave port of the motor routing stage.

---
 rtl/fsmotor_pkg.sv | 20 ++
 rtl/fsmotor_sync.sv | 27 ++
 rtl/fsmotor_stepgen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fsmotor_pkg.sv
// Purpose : shared state encoding and period limits for the step/dir pulse generator.
// Latency : n/a (types, constants, and one combinational helper).
// Backpr. : n/a.
package fsmotor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Shortest legal step period: one cycle high, one cycle low.
    localparam int C_MIN_PERIOD = 2;

    // Raise a requested period to the shortest one that still gives a full pulse.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p < 32'(C_MIN_PERIOD)) ? 32'(C_MIN_PERIOD) : p;
    endfunction

endpackage

// File: rtl/fsmotor_sync.sv
// Purpose : two-flop synchroniser that brings the asynchronous zero-position flag into the clk domain.
// Latency : 2 clk cycles from the sampling edge to o_sync.
// Backpr. : none; free-running level path.
module fsmotor_sync (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // The first flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/fsmotor_stepgen.sv
// Purpose : turns a host move command into a step/dir pulse train for one motor routing slave port.
// Latency : first drive rise C_DIR_SETUP+1 cycles after the accepting edge; control copies 1 cycle; zpd 2 cycles.
// Backpr. : none; commands arriving while busy are dropped. Optional FSMOTOR_ZPD_STOP_EN makes zpd halt homeward moves.
module fsmotor_stepgen
    import fsmotor_pkg::*;
#(
    parameter int C_MICROSTEP_WIDTH = 3,
    parameter int C_SPEED_WIDTH     = 16,
    parameter int C_STEP_WIDTH      = 32,
    parameter int C_DIR_SETUP       = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ctl_start,
    input  logic                         ctl_stop,
    input  logic                         ctl_dir,
    input  logic [C_SPEED_WIDTH-1:0]     ctl_speed,
    input  logic [C_STEP_WIDTH-1:0]      ctl_step,
    input  logic [C_MICROSTEP_WIDTH-1:0] ctl_ms,
    input  logic                         ctl_xen,
    input  logic                         ctl_xrst,
    output logic                         ctl_busy,
    output logic                         ctl_done,
    output logic [C_STEP_WIDTH-1:0]      ctl_remain,
    output logic                         ctl_zpd,
    input  logic                         m_zpd,
    output logic                         m_xen,
    output logic                         m_xrst,
    output logic                         m_drive,
    output logic                         m_dir,
    output logic [C_MICROSTEP_WIDTH-1:0] m_ms
);

    localparam int C_SETUP_W = (C_DIR_SETUP < 2) ? 1 : $clog2(C_DIR_SETUP + 1);
    localparam logic [C_SETUP_W-1:0]     SETUP_LOAD = C_SETUP_W'(C_DIR_SETUP);
    localparam logic [C_SETUP_W-1:0]     SETUP_ONE  = C_SETUP_W'(1);
    localparam logic [C_SPEED_WIDTH-1:0] SPEED_ONE  = C_SPEED_WIDTH'(1);
    localparam logic [C_STEP_WIDTH-1:0]  STEP_ONE   = C_STEP_WIDTH'(1);

    state_t                         r_state;
    logic [C_SETUP_W-1:0]           r_setup_cnt;
    logic [C_SPEED_WIDTH-1:0]       r_phase_cnt;
    logic [C_SPEED_WIDTH-1:0]       r_lo_len;
    logic                           r_stop_pend;
    logic                           r_drive;
    logic                           r_dir;
    logic                           r_done;
    logic [C_STEP_WIDTH-1:0]        r_remain;
    logic                           r_xen;
    logic                           r_xrst;
    logic [C_MICROSTEP_WIDTH-1:0]   r_ms;

    logic                           w_zpd;
    logic [C_SPEED_WIDTH-1:0]       w_period;
    logic [C_SPEED_WIDTH-1:0]       w_hi_len;
    logic [C_SPEED_WIDTH-1:0]       w_lo_len;
    logic                           w_start_ok;
    logic                           w_stop_req;
    logic                           w_last;

    fsmotor_sync u_zpd_sync (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_async  (m_zpd),
        .o_sync   (w_zpd)
    );

    // Period is sampled only at a step boundary, so the host may ramp speed mid-move.
    assign w_period = C_SPEED_WIDTH'(clamp_period(32'(ctl_speed)));
    assign w_hi_len = w_period >> 1;
    assign w_lo_len = w_period - w_hi_len;
    assign w_last   = (r_remain <= STEP_ONE);

`ifdef FSMOTOR_ZPD_STOP_EN
    // Already at home: refuse further homeward moves and halt one in progress.
    assign w_start_ok = ctl_start && !ctl_stop && (ctl_step != '0) && !ctl_xen && !(!ctl_dir && w_zpd);
    assign w_stop_req = ctl_stop || ((r_state == ST_RUN) && !r_dir && w_zpd);
`else
    assign w_start_ok = ctl_start && !ctl_stop && (ctl_step != '0) && !ctl_xen;
    assign w_stop_req = ctl_stop;
`endif

    // Move sequencer: direction setup, then whole high/low step periods until count or stop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_setup_cnt <= '0;
            r_phase_cnt <= '0;
            r_lo_len    <= '0;
            r_stop_pend <= 1'b0;
            r_drive     <= 1'b0;
            r_dir       <= 1'b0;
            r_done      <= 1'b0;
            r_remain    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_drive     <= 1'b0;
                    r_stop_pend <= 1'b0;
                    if (w_start_ok) begin
                        r_dir       <= ctl_dir;
                        r_remain    <= ctl_step;
                        r_setup_cnt <= SETUP_LOAD;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (ctl_xen || w_stop_req) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else if (r_setup_cnt == '0) begin
                        r_state     <= ST_RUN;
                        r_drive     <= 1'b1;
                        r_phase_cnt <= w_hi_len - SPEED_ONE;
                        r_lo_len    <= w_lo_len;
                    end else begin
                        r_setup_cnt <= r_setup_cnt - SETUP_ONE;
                    end
                end
                ST_RUN: begin
                    if (ctl_xen) begin
                        // Driver disabled underneath us: the one abort allowed to cut a pulse short.
                        r_state <= ST_IDLE;
                        r_drive <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        if (w_stop_req) begin
                            r_stop_pend <= 1'b1;
                        end
                        if (r_drive) begin
                            if (r_phase_cnt == '0) begin
                                r_drive     <= 1'b0;
                                r_phase_cnt <= r_lo_len - SPEED_ONE;
                            end else begin
                                r_phase_cnt <= r_phase_cnt - SPEED_ONE;
                            end
                        end else if (r_phase_cnt == '0) begin
                            // End of a whole step: count it, then finish or launch the next one.
                            if (r_remain != '0) begin
                                r_remain <= r_remain - STEP_ONE;
                            end
                            if (w_last || r_stop_pend || w_stop_req) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_drive     <= 1'b1;
                                r_phase_cnt <= w_hi_len - SPEED_ONE;
                                r_lo_len    <= w_lo_len;
                            end
                        end else begin
                            r_phase_cnt <= r_phase_cnt - SPEED_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_drive <= 1'b0;
                end
            endcase
        end
    end

    // Driver control lines are plain registered copies, unaffected by move state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_xen  <= 1'b1;
            r_xrst <= 1'b0;
            r_ms   <= '0;
        end else begin
            r_xen  <= ctl_xen;
            r_xrst <= ctl_xrst;
            r_ms   <= ctl_ms;
        end
    end

    assign ctl_busy   = (r_state != ST_IDLE);
    assign ctl_done   = r_done;
    assign ctl_remain = r_remain;
    assign ctl_zpd    = w_zpd;
    assign m_xen      = r_xen;
    assign m_xrst     = r_xrst;
    assign m_drive    = r_drive;
    assign m_dir      = r_dir;
    assign m_ms       = r_ms;

endmodule
